// File: rtl/dm_cache_core.sv
// Direct-mapped, write-through, no-write-allocate cache with one-word lines.
// It handles one outstanding core request at a time. Read misses and all
// writes are forwarded to a word-wide memory port.
module dm_cache_core #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LINES  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    core_req_valid,
  output logic                    core_req_ready,
  input  logic                    core_req_we,
  input  logic [ADDR_WIDTH-1:0]   core_req_addr,
  input  logic [DATA_WIDTH-1:0]   core_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] core_req_wstrb,
  output logic                    core_resp_valid,
  output logic                    core_resp_is_write,
  output logic [DATA_WIDTH-1:0]   core_resp_rdata,
  output logic [1:0]              core_resp_resp,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_we,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_rdata,
  input  logic [1:0]              mem_resp_resp,
  input  logic                    inv_all,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int OFS = $clog2(SW);
  localparam int IW  = $clog2(NUM_LINES);
  localparam int TW  = ADDR_WIDTH - OFS - IW;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MEM_REQ, S_MEM_WAIT, S_RESP} state_t;

  state_t                  r_state;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [SW-1:0]           r_wstrb;
  logic                    r_hit;
  logic                    r_inv_pend;
  logic [NUM_LINES-1:0]    r_valid;
  logic [TW-1:0]           r_tag  [NUM_LINES];
  logic [DATA_WIDTH-1:0]   r_data [NUM_LINES];
  logic                    r_resp_valid;
  logic                    r_resp_is_write;
  logic [DATA_WIDTH-1:0]   r_resp_rdata;
  logic [1:0]              r_resp_resp;
  logic                    r_mem_req_valid;
  logic [31:0]             r_hit_cnt;
  logic [31:0]             r_miss_cnt;

  logic [IW-1:0]           w_idx;
  logic [TW-1:0]           w_tag;
  logic                    w_lookup_hit;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_inv_now;
  logic                    w_resp_ok;
  logic                    w_fill;
  logic                    w_merge;

  // Overlay the bytes of nw selected by strb onto old.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] nw,
    input logic [SW-1:0]         strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) res[b*8 +: 8] = nw[b*8 +: 8];
    end
    return res;
  endfunction

  // The counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  assign w_idx        = r_addr[OFS+IW-1:OFS];
  assign w_tag        = r_addr[ADDR_WIDTH-1:OFS+IW];
  assign w_lookup_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // An invalidate, whether arriving now or pending, blocks accept for the cycle it is applied.
  assign w_ready      = (r_state == S_IDLE) && !r_inv_pend && !inv_all && !rst;
  assign w_accept     = core_req_valid && w_ready;
  assign w_inv_now    = (r_state == S_IDLE) && (inv_all || r_inv_pend);
  assign w_resp_ok    = (mem_resp_resp == 2'b00);
  assign w_fill       = !rst && (r_state == S_MEM_WAIT) && mem_resp_valid && !r_we && w_resp_ok;
  assign w_merge      = !rst && (r_state == S_MEM_WAIT) && mem_resp_valid && r_we && w_resp_ok && r_hit;

  assign core_req_ready     = w_ready;
  assign core_resp_valid    = r_resp_valid;
  assign core_resp_is_write = r_resp_is_write;
  assign core_resp_rdata    = r_resp_rdata;
  assign core_resp_resp     = r_resp_resp;
  assign mem_req_valid      = r_mem_req_valid;
  assign mem_req_we         = r_we;
  assign mem_req_addr       = r_addr;
  assign mem_req_wdata      = r_wdata;
  assign mem_req_wstrb      = r_wstrb;
  assign hit_cnt            = r_hit_cnt;
  assign miss_cnt           = r_miss_cnt;

  // Control FSM: holds the request, valid bits, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_we            <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_wstrb         <= '0;
      r_hit           <= 1'b0;
      r_inv_pend      <= 1'b0;
      r_valid         <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_is_write <= 1'b0;
      r_resp_rdata    <= '0;
      r_resp_resp     <= 2'b00;
      r_mem_req_valid <= 1'b0;
      r_hit_cnt       <= '0;
      r_miss_cnt      <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_inv_now) begin
            r_valid    <= '0;
            r_inv_pend <= 1'b0;
          end else if (w_accept) begin
            r_we    <= core_req_we;
            r_addr  <= core_req_addr;
            r_wdata <= core_req_wdata;
            r_wstrb <= core_req_wstrb;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_hit <= w_lookup_hit;
          if (!r_we && w_lookup_hit) begin
            r_resp_valid    <= 1'b1;
            r_resp_is_write <= 1'b0;
            r_resp_rdata    <= r_data[w_idx];
            r_resp_resp     <= 2'b00;
            r_hit_cnt       <= sat_inc(r_hit_cnt);
            r_state         <= S_RESP;
          end else begin
            if (!r_we) r_miss_cnt <= sat_inc(r_miss_cnt);
            r_mem_req_valid <= 1'b1;
            r_state         <= S_MEM_REQ;
          end
        end
        S_MEM_REQ: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= S_MEM_WAIT;
          end
        end
        S_MEM_WAIT: begin
          if (mem_resp_valid) begin
            r_resp_valid    <= 1'b1;
            r_resp_is_write <= r_we;
            r_resp_rdata    <= r_we ? '0 : mem_resp_rdata;
            r_resp_resp     <= mem_resp_resp;
            if (w_fill) r_valid[w_idx] <= 1'b1;
            r_state         <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      // Remember an invalidate seen mid-operation until the FSM returns to IDLE.
      if (inv_all && (r_state != S_IDLE)) r_inv_pend <= 1'b1;
    end
  end

  // Tag/data storage is not reset; validity is tracked by r_valid.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= mem_resp_rdata;
    end else if (w_merge) begin
      r_data[w_idx] <= merge_bytes(r_data[w_idx], r_wdata, r_wstrb);
    end
  end
endmodule

// File: tb/tb_dm_cache_core.sv
// Directed bench for dm_cache_core with a small memory responder.
module tb_dm_cache_core;
  logic        clk = 1'b0;
  logic        rst;
  logic        core_req_valid, core_req_ready, core_req_we;
  logic [31:0] core_req_addr, core_req_wdata;
  logic [3:0]  core_req_wstrb;
  logic        core_resp_valid, core_resp_is_write;
  logic [31:0] core_resp_rdata;
  logic [1:0]  core_resp_resp;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic [1:0]  mem_resp_resp;
  logic        inv_all;
  logic [31:0] hit_cnt, miss_cnt;

  int total = 0;
  int bad   = 0;

  logic        got_mem, got_resp, m_we, o_isw;
  logic [31:0] m_addr, m_wdata, o_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  o_resp;
  int          lat;

  dm_cache_core #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_LINES(16)) dut (
    .clk(clk), .rst(rst),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_we(core_req_we), .core_req_addr(core_req_addr),
    .core_req_wdata(core_req_wdata), .core_req_wstrb(core_req_wstrb),
    .core_resp_valid(core_resp_valid), .core_resp_is_write(core_resp_is_write),
    .core_resp_rdata(core_resp_rdata), .core_resp_resp(core_resp_resp),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .mem_resp_resp(mem_resp_resp), .inv_all(inv_all),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one core request; answer any memory request with (mrd, mrs).
  // Returns at the negedge where core_resp_valid is seen (or on timeout).
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input logic [31:0] mrd, input logic [1:0] mrs,
                     input logic inv_wait);
    int  cyc;
    logic pend;
    got_mem = 1'b0; got_resp = 1'b0; pend = 1'b0;
    @(negedge clk);
    core_req_valid = 1'b1; core_req_we = we; core_req_addr = addr;
    core_req_wdata = wdata; core_req_wstrb = wstrb;
    cyc = 0;
    while (!core_req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    core_req_valid = 1'b0;
    lat = 1;
    while (!got_resp && lat < 40) begin
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; inv_all = 1'b0;
      if (core_resp_valid) begin
        got_resp = 1'b1;
        o_rdata = core_resp_rdata; o_resp = core_resp_resp; o_isw = core_resp_is_write;
      end else begin
        if (pend) begin
          mem_resp_valid = 1'b1; mem_resp_rdata = mrd; mem_resp_resp = mrs;
          inv_all = inv_wait; pend = 1'b0;
        end else if (mem_req_valid && !got_mem) begin
          got_mem = 1'b1; m_we = mem_req_we; m_addr = mem_req_addr;
          m_wdata = mem_req_wdata; m_wstrb = mem_req_wstrb;
          mem_req_ready = 1'b1; pend = 1'b1;
        end
        @(negedge clk);
        lat++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; core_req_valid = 1'b0; core_req_we = 1'b0; core_req_addr = '0;
    core_req_wdata = '0; core_req_wstrb = '0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_rdata = '0; mem_resp_resp = 2'b00; inv_all = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, core_req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, core_resp_valid}, 32'd0);
    chk("rst_mem_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_hit", hit_cnt, 32'd0);
    chk("rst_miss", miss_cnt, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, core_req_ready}, 32'd1);

    // 1: cold read miss
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'h12345678, 2'b00, 1'b0);
    chk("t1_got_resp", {31'd0, got_resp}, 32'd1);
    chk("t1_got_mem", {31'd0, got_mem}, 32'd1);
    chk("t1_mem_we", {31'd0, m_we}, 32'd0);
    chk("t1_mem_addr", m_addr, 32'h10);
    chk("t1_rdata", o_rdata, 32'h12345678);
    chk("t1_resp", {30'd0, o_resp}, 32'd0);
    chk("t1_miss", miss_cnt, 32'd1);
    @(negedge clk);
    chk("t1_resp_one_cycle", {31'd0, core_resp_valid}, 32'd0);

    // 2: read hit
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hFFFFFFFF, 2'b00, 1'b0);
    chk("t2_no_mem", {31'd0, got_mem}, 32'd0);
    chk("t2_latency", lat, 32'd2);
    chk("t2_rdata", o_rdata, 32'h12345678);
    chk("t2_hit", hit_cnt, 32'd1);

    // 3: partial write hit then read back merged word
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'b0011, 32'hFFFFFFFF, 2'b00, 1'b0);
    chk("t3_mem_we", {31'd0, m_we}, 32'd1);
    chk("t3_mem_wstrb", {28'd0, m_wstrb}, 32'h3);
    chk("t3_mem_wdata", m_wdata, 32'hDEADBEEF);
    chk("t3_is_write", {31'd0, o_isw}, 32'd1);
    chk("t3_wr_rdata", o_rdata, 32'd0);
    chk("t3_miss_unchanged", miss_cnt, 32'd1);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hFFFFFFFF, 2'b00, 1'b0);
    chk("t3_rd_hit", {31'd0, got_mem}, 32'd0);
    chk("t3_rd_merged", o_rdata, 32'h1234BEEF);
    chk("t3_hit", hit_cnt, 32'd2);

    // 4: conflict on index 4
    txn(1'b0, 32'h50, 32'h0, 4'h0, 32'hAAAA5555, 2'b00, 1'b0);
    chk("t4a_mem", {31'd0, got_mem}, 32'd1);
    chk("t4a_addr", m_addr, 32'h50);
    chk("t4a_rdata", o_rdata, 32'hAAAA5555);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'h1234BEEF, 2'b00, 1'b0);
    chk("t4b_mem", {31'd0, got_mem}, 32'd1);
    chk("t4b_addr", m_addr, 32'h10);
    chk("t4_miss", miss_cnt, 32'd3);

    // 5: memory error is reported and does not fill
    txn(1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 2'b10, 1'b0);
    chk("t5_resp_err", {30'd0, o_resp}, 32'h2);
    txn(1'b0, 32'h20, 32'h0, 4'h0, 32'h0BADF00D, 2'b00, 1'b0);
    chk("t5_remiss", {31'd0, got_mem}, 32'd1);
    chk("t5_rdata", o_rdata, 32'h0BADF00D);
    chk("t5_miss", miss_cnt, 32'd5);

    // 6: invalidate during MEM_WAIT
    txn(1'b0, 32'h30, 32'h0, 4'h0, 32'h33333333, 2'b00, 1'b1);
    chk("t6_completes", o_rdata, 32'h33333333);
    @(negedge clk);
    chk("t6_inv_blocks_ready", {31'd0, core_req_ready}, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'h1234BEEF, 2'b00, 1'b0);
    chk("t6_miss_after_inv", {31'd0, got_mem}, 32'd1);
    chk("t6_miss", miss_cnt, 32'd7);
    chk("t6_hit", hit_cnt, 32'd2);

    // Reset while a write waits in MEM_REQ
    @(negedge clk);
    core_req_valid = 1'b1; core_req_we = 1'b1; core_req_addr = 32'h40;
    core_req_wdata = 32'h1; core_req_wstrb = 4'hF;
    @(negedge clk);
    core_req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_valid_before", {31'd0, mem_req_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_mem_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, core_req_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready_after", {31'd0, core_req_ready}, 32'd1);
    chk("rst_mid_miss", miss_cnt, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'h1234BEEF, 2'b00, 1'b0);
    chk("rst_mid_cold_miss", {31'd0, got_mem}, 32'd1);
    chk("rst_mid_miss_cnt", miss_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
